// File: rtl/inferred_sram_1rw1r_be.sv
// Inferred dual-port SRAM: port 0 read/write with byte enables, port 1 read-only.
// Includes registered read-valid flags, an optional output stage, collision bypass and a clear engine.
module inferred_sram_1rw1r_be #(
  parameter int ASIZE          = 8,
  parameter int DSIZE          = 32,
  parameter int BSIZE          = 8,
  parameter int OREG           = 0,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     ready,
  input  logic                     cs0_n,
  input  logic                     we0_n,
  input  logic [DSIZE/BSIZE-1:0]   be0,
  input  logic [ASIZE-1:0]         addr0,
  input  logic [DSIZE-1:0]         wdata0,
  output logic [DSIZE-1:0]         rdata0,
  output logic                     rvalid0,
  input  logic                     cs1_n,
  input  logic [ASIZE-1:0]         addr1,
  output logic [DSIZE-1:0]         rdata1,
  output logic                     rvalid1
);

  localparam int NB    = DSIZE / BSIZE;
  localparam int DEPTH = 1 << ASIZE;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t             state_reg, state_next;
  logic [ASIZE-1:0]   cnt_reg, cnt_next;
  logic               ready_reg;
  logic               clearing;

  logic               rd0_req_reg, wr0_req_reg, rd1_req_reg;
  logic [NB-1:0]      be0_reg;
  logic [ASIZE-1:0]   addr0_reg, addr1_reg;
  logic [DSIZE-1:0]   wdata0_reg;

  logic [ASIZE-1:0]   waddr;
  logic               collide;
  logic [DSIZE-1:0]   s1_data0, s1_data1;
  logic               s1_valid0_reg, s1_valid1_reg;

  // Clear/ready state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ready_reg <= (state_next == ST_READY);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == '1) state_next = ST_READY;
      end
      ST_READY: begin
        if (clr && ready_reg) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      default: state_next = ST_READY;
    endcase
  end

  assign clearing = (state_reg == ST_CLEAR);
  assign ready    = ready_reg;

  // Request stage: selects are qualified by ready so accesses during a clear vanish
  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_req_reg <= 1'b0;
      wr0_req_reg <= 1'b0;
      rd1_req_reg <= 1'b0;
    end else begin
      rd0_req_reg <= ready_reg & ~cs0_n & we0_n;
      wr0_req_reg <= ready_reg & ~cs0_n & ~we0_n;
      rd1_req_reg <= ready_reg & ~cs1_n;
    end
  end

  always_ff @(posedge clk) begin
    be0_reg    <= be0;
    addr0_reg  <= addr0;
    addr1_reg  <= addr1;
    wdata0_reg <= wdata0;
  end

  // The clear engine borrows the port-0 write path; a write racing a clear is wiped anyway
  assign waddr   = clearing ? cnt_reg : addr0_reg;
  assign collide = wr0_req_reg & rd1_req_reg & (addr0_reg == addr1_reg) & ~clearing & (BYPASS != 0);

  // One narrow RAM per byte lane keeps the byte-enable write inferable
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [BSIZE-1:0] mem [DEPTH];
    logic             lane_we;
    logic [BSIZE-1:0] lane_wdata;
    logic [BSIZE-1:0] q0_lane_reg, q1_lane_reg;

    assign lane_we    = clearing | (wr0_req_reg & be0_reg[gi]);
    assign lane_wdata = clearing ? '0 : wdata0_reg[gi*BSIZE +: BSIZE];

    always_ff @(posedge clk) begin
      if (lane_we) mem[waddr] <= lane_wdata;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        q0_lane_reg <= '0;
        q1_lane_reg <= '0;
      end else begin
        if (rd0_req_reg) q0_lane_reg <= mem[addr0_reg];
        if (rd1_req_reg) q1_lane_reg <= (collide && be0_reg[gi]) ?
                                        wdata0_reg[gi*BSIZE +: BSIZE] : mem[addr1_reg];
      end
    end

    assign s1_data0[gi*BSIZE +: BSIZE] = q0_lane_reg;
    assign s1_data1[gi*BSIZE +: BSIZE] = q1_lane_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid0_reg <= 1'b0;
      s1_valid1_reg <= 1'b0;
    end else begin
      s1_valid0_reg <= rd0_req_reg;
      s1_valid1_reg <= rd1_req_reg;
    end
  end

  if (OREG != 0) begin : g_oreg
    logic [DSIZE-1:0] o0_reg, o1_reg;
    logic             ov0_reg, ov1_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        o0_reg  <= '0;
        o1_reg  <= '0;
        ov0_reg <= 1'b0;
        ov1_reg <= 1'b0;
      end else begin
        ov0_reg <= s1_valid0_reg;
        ov1_reg <= s1_valid1_reg;
        if (s1_valid0_reg) o0_reg <= s1_data0;
        if (s1_valid1_reg) o1_reg <= s1_data1;
      end
    end

    assign rdata0  = o0_reg;
    assign rdata1  = o1_reg;
    assign rvalid0 = ov0_reg;
    assign rvalid1 = ov1_reg;
  end else begin : g_no_oreg
    assign rdata0  = s1_data0;
    assign rdata1  = s1_data1;
    assign rvalid0 = s1_valid0_reg;
    assign rvalid1 = s1_valid1_reg;
  end

endmodule

// File: tb/tb_inferred_sram_1rw1r_be.sv
// Scoreboard bench: two SRAM builds (bypass/no-oreg and no-bypass/oreg) share one stimulus stream.
`timescale 1ns/1ps
module tb_inferred_sram_1rw1r_be;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NB    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clr, cs0_n, we0_n, cs1_n;
  logic [NB-1:0] be0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0;

  logic          ready_a, rvalid0_a, rvalid1_a, ready_b, rvalid0_b, rvalid1_b;
  logic [DW-1:0] rdata0_a, rdata1_a, rdata0_b, rdata1_b;

  inferred_sram_1rw1r_be #(.ASIZE(AW), .DSIZE(DW), .BSIZE(8), .OREG(0), .BYPASS(1), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready_a),
    .cs0_n(cs0_n), .we0_n(we0_n), .be0(be0), .addr0(addr0), .wdata0(wdata0),
    .rdata0(rdata0_a), .rvalid0(rvalid0_a),
    .cs1_n(cs1_n), .addr1(addr1), .rdata1(rdata1_a), .rvalid1(rvalid1_a)
  );

  inferred_sram_1rw1r_be #(.ASIZE(AW), .DSIZE(DW), .BSIZE(8), .OREG(1), .BYPASS(0), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready_b),
    .cs0_n(cs0_n), .we0_n(we0_n), .be0(be0), .addr0(addr0), .wdata0(wdata0),
    .rdata0(rdata0_b), .rvalid0(rvalid0_b),
    .cs1_n(cs1_n), .addr1(addr1), .rdata1(rdata1_b), .rvalid1(rvalid1_b)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  // Queues: 0 = port0 of a, 1 = port1 of a, 2 = port0 of b, 3 = port1 of b
  exp_t          exp_q [4][$];
  string         pname [4] = '{"port0_a", "port1_a", "port0_b", "port1_b"};
  logic [DW-1:0] model_mem [DEPTH];
  bit            model_ready = 1'b0;
  int            clear_left  = DEPTH;
  int            edge_cnt    = 0;
  int            n_vec       = 0;
  int            n_err       = 0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++)
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  function automatic void push(input int idx, input logic [DW-1:0] d, input int due);
    exp_t e;
    e.data = d;
    e.due  = due;
    exp_q[idx].push_back(e);
  endfunction

  function automatic void zero_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endfunction

  // Reference behaviour for one rising edge, from the inputs present at that edge
  task automatic model_edge();
    logic [DW-1:0] old1;
    edge_cnt++;
    if (rst) begin
      model_ready = 1'b0;
      clear_left  = DEPTH;
      zero_model();
    end else if (!model_ready) begin
      if (clear_left > 0) clear_left--;
      if (clear_left == 0) model_ready = 1'b1;
    end else begin
      if (!cs0_n && we0_n) begin
        push(0, model_mem[addr0], edge_cnt + 1);
        push(2, model_mem[addr0], edge_cnt + 2);
      end
      if (!cs1_n) begin
        old1 = model_mem[addr1];
        push(3, old1, edge_cnt + 2);
        if (!cs0_n && !we0_n && addr0 == addr1) push(1, merge(old1, wdata0, be0), edge_cnt + 1);
        else                                    push(1, old1, edge_cnt + 1);
      end
      if (!cs0_n && !we0_n) model_mem[addr0] = merge(model_mem[addr0], wdata0, be0);
      if (clr) begin
        model_ready = 1'b0;
        clear_left  = DEPTH;
        zero_model();
      end
    end
  endtask

  task automatic chk_port(input int idx, input logic v, input logic [DW-1:0] d);
    exp_t e;
    if (v === 1'b1) begin
      n_vec++;
      if (exp_q[idx].size() == 0) begin
        n_err++;
        $display("FAIL %s unexpected rvalid cyc=%0d got=%08h required=none", pname[idx], edge_cnt, d);
      end else begin
        e = exp_q[idx].pop_front();
        if (d !== e.data || edge_cnt != e.due) begin
          n_err++;
          $display("FAIL %s read got=%08h@%0d required=%08h@%0d", pname[idx], d, edge_cnt, e.data, e.due);
        end else begin
          $display("rd %s cyc=%0d data=%08h ok", pname[idx], edge_cnt, d);
        end
      end
    end else if (exp_q[idx].size() != 0 && exp_q[idx][0].due <= edge_cnt) begin
      n_vec++;
      n_err++;
      e = exp_q[idx].pop_front();
      $display("FAIL %s missing rvalid cyc=%0d required=%08h@%0d", pname[idx], edge_cnt, e.data, e.due);
    end
  endtask

  // Monitor: samples 1 ns after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (edge_cnt >= 1) begin
        n_vec += 2;
        if (ready_a !== model_ready) begin
          n_err++;
          $display("FAIL ready_a cyc=%0d got=%b required=%b", edge_cnt, ready_a, model_ready);
        end
        if (ready_b !== model_ready) begin
          n_err++;
          $display("FAIL ready_b cyc=%0d got=%b required=%b", edge_cnt, ready_b, model_ready);
        end
        chk_port(0, rvalid0_a, rdata0_a);
        chk_port(1, rvalid1_a, rdata1_a);
        chk_port(2, rvalid0_b, rdata0_b);
        chk_port(3, rvalid1_b, rdata1_b);
      end
    end
  end

  task automatic idle_inputs();
    rst = 1'b0; clr = 1'b0;
    cs0_n = 1'b1; we0_n = 1'b1; cs1_n = 1'b1;
    be0 = '0; addr0 = '0; addr1 = '0; wdata0 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cmp(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%08h required=%08h", name, got, want);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 40 && !(ready_a === 1'b1 && ready_b === 1'b1); i++) tick();
    n_vec++;
    if (!(ready_a === 1'b1 && ready_b === 1'b1)) begin
      n_err++;
      $display("FAIL ready_timeout got=%b%b required=11", ready_a, ready_b);
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      cs0_n = 1'b0; we0_n = 1'b1; addr0 = AW'(a);
      cs1_n = 1'b0; addr1 = AW'(DEPTH - 1 - a);
      tick();
    end
    idle_inputs();
  endtask

  task automatic write0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    cs0_n = 1'b0; we0_n = 1'b0; addr0 = a; wdata0 = d; be0 = be;
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      cs0_n  = ($urandom_range(0, 3) == 0);
      we0_n  = $urandom_range(0, 1) == 1;
      be0    = NB'($urandom_range(0, 15));
      addr0  = AW'($urandom_range(0, DEPTH - 1));
      wdata0 = $urandom;
      cs1_n  = ($urandom_range(0, 3) == 0);
      addr1  = ($urandom_range(0, 1) == 1) ? addr0 : AW'($urandom_range(0, DEPTH - 1));
      tick();
    end
    idle_inputs();
  endtask

  task automatic idle(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("reset_rdata0_a", rdata0_a, '0);
    cmp("reset_rdata1_a", rdata1_a, '0);
    cmp("reset_rdata0_b", rdata0_b, '0);
    cmp("reset_rdata1_b", rdata1_b, '0);
    cmp("reset_rvalid", {28'd0, rvalid0_a, rvalid1_a, rvalid0_b, rvalid1_b}, '0);
    wait_ready();
    read_all();

    write0(4'd5, 32'hDEADBEEF, 4'b1111);
    tick();
    idle_inputs();
    cs1_n = 1'b0; addr1 = 4'd5;
    tick();
    write0(4'd5, 32'h11223344, 4'b0101);
    tick();
    idle_inputs();
    cs0_n = 1'b0; we0_n = 1'b1; addr0 = 4'd5; cs1_n = 1'b0; addr1 = 4'd5;
    tick();
    write0(4'd3, 32'hA5A5A5A5, 4'b1111);
    cs1_n = 1'b0; addr1 = 4'd3;
    tick();
    idle_inputs();
    cs1_n = 1'b0; addr1 = 4'd3;
    tick();
    write0(4'd9, 32'h12345678, 4'b0000);
    tick();
    idle_inputs();
    cs0_n = 1'b0; we0_n = 1'b1; addr0 = 4'd9;
    tick();
    idle(4);

    random_traffic(400);
    idle(4);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cs0_n = 1'b0; we0_n = (i % 2 == 0); addr0 = AW'(i); wdata0 = $urandom; be0 = 4'hF;
      cs1_n = 1'b0; addr1 = AW'(i);
      tick();
    end
    idle_inputs();
    wait_ready();
    read_all();

    random_traffic(100);
    idle(4);
    clr = 1'b1;
    tick();
    idle(7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready();
    read_all();

    random_traffic(150);
    idle(6);
    for (int q = 0; q < 4; q++) begin
      n_vec++;
      if (exp_q[q].size() != 0) begin
        n_err++;
        $display("FAIL %s drain pending=%0d required=0", pname[q], exp_q[q].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
